// File: rtl/gray_rr_sched.sv
// gray_rr_sched: round-robin arbiter in front of one shared Gray-to-binary stage.
// The result goes out through a one-entry valid/ready output register.
// Optional macro GRAY_SCHED_CHK_EN adds per-requester Gray-step error tracking.
// Without it, err is tied to 0.
//
// state    | meaning
// ST_EMPTY | output register holds no word, out_valid=0
// ST_FULL  | output register holds a converted word, out_valid=1
module gray_rr_sched #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_gray,
  output logic [NREQ-1:0]         req_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_bin,
  output logic [$clog2(NREQ)-1:0] out_id,
  output logic [NREQ-1:0]         err
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic {ST_EMPTY, ST_FULL} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [IDW-1:0]   ptr_q, ptr_d;

  logic             can_load;
  logic             grant_vld;
  logic [IDW-1:0]   grant_idx;
  logic             do_grant;
  logic [WIDTH-1:0] grant_gray;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int k = WIDTH - 2; k >= 0; k--) begin
      b[k] = b[k+1] ^ g[k];
    end
    return b;
  endfunction

  // Rotating priority search: the first valid requester at or after ptr wins.
  always_comb begin
    int idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!grant_vld && req_valid[idx]) begin
        grant_vld = 1'b1;
        grant_idx = IDW'(idx);
      end
    end
  end

  assign can_load   = (state_q == ST_EMPTY) || out_ready;
  // Reset blocks the handshake so nothing is consumed during the reset cycle.
  assign do_grant   = can_load && grant_vld && !rst;
  assign grant_gray = req_gray[int'(grant_idx)*WIDTH +: WIDTH];
  assign req_ready  = do_grant ? (NREQ'(1) << grant_idx) : '0;

  // Output register next state: load on grant, drain on pop, otherwise hold.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    if (do_grant) begin
      state_d = ST_FULL;
      bin_d   = gray2bin(grant_gray);
      id_d    = grant_idx;
      ptr_d   = (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;
    end else if (state_q == ST_FULL && out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  // State, data and pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      bin_q   <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_bin   = bin_q;
  assign out_id    = id_q;

`ifdef GRAY_SCHED_CHK_EN
  logic [NREQ-1:0][WIDTH-1:0] last_q, last_d;
  logic [NREQ-1:0]            seen_q, seen_d;
  logic [NREQ-1:0]            err_q, err_d;

  function automatic int popcnt(input logic [WIDTH-1:0] v);
    int n;
    n = 0;
    for (int k = 0; k < WIDTH; k++) begin
      n += int'(v[k]);
    end
    return n;
  endfunction

  // History update: a step of more than one bit from the previous word is sticky.
  always_comb begin
    last_d = last_q;
    seen_d = seen_q;
    err_d  = err_q;
    if (do_grant) begin
      last_d[grant_idx] = grant_gray;
      seen_d[grant_idx] = 1'b1;
      if (seen_q[grant_idx] && (popcnt(grant_gray ^ last_q[grant_idx]) > 1)) begin
        err_d[grant_idx] = 1'b1;
      end
    end
  end

  // History and error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= '0;
      seen_q <= '0;
      err_q  <= '0;
    end else begin
      last_q <= last_d;
      seen_q <= seen_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = '0;
`endif

endmodule
